// File: rtl/reduce_tree_dist.sv
// Pipelined log-depth lane reduction (add/max/select/min) followed by a FRAME_LEN-beat accumulator.
// Define REDUCE_TREE_DIST_SAT_EN to make op 0 saturate instead of wrapping.
module reduce_tree_dist #(
  parameter int NUM_PES   = 4,
  parameter int DATA_TYPE = 16,
  parameter int FRAME_LEN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   op,
  input  logic [NUM_PES*DATA_TYPE-1:0] data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_TYPE-1:0]         data_out
);

  function automatic int lvl_cnt(input int l);
    int n;
    n = NUM_PES;
    for (int k = 0; k < l; k++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int lvl_off(input int l);
    int s;
    s = 0;
    for (int k = 0; k < l; k++) s = s + lvl_cnt(k);
    return s;
  endfunction

  localparam int L     = $clog2(NUM_PES);
  localparam int TOT   = lvl_off(L + 1);
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
  localparam logic signed [DATA_TYPE-1:0] SMAX = {1'b0, {(DATA_TYPE-1){1'b1}}};
  localparam logic signed [DATA_TYPE-1:0] SMIN = {1'b1, {(DATA_TYPE-1){1'b0}}};

  function automatic logic signed [DATA_TYPE-1:0] add_fn(
    input logic signed [DATA_TYPE-1:0] a,
    input logic signed [DATA_TYPE-1:0] b
  );
`ifdef REDUCE_TREE_DIST_SAT_EN
    logic signed [DATA_TYPE:0] s;
    s = {a[DATA_TYPE-1], a} + {b[DATA_TYPE-1], b};
    if (s[DATA_TYPE] != s[DATA_TYPE-1]) return s[DATA_TYPE] ? SMIN : SMAX;
    return s[DATA_TYPE-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic signed [DATA_TYPE-1:0] combine(
    input logic [1:0]                  o,
    input logic signed [DATA_TYPE-1:0] a,
    input logic signed [DATA_TYPE-1:0] b
  );
    case (o)
      2'd0:    return add_fn(a, b);
      2'd1:    return (a > b) ? a : b;
      2'd2:    return a[0] ? a : b;
      default: return (a < b) ? a : b;
    endcase
  endfunction

  // tree_q packs every level: level 0 (registered lanes) at the bottom, the single root on top
  logic [TOT*DATA_TYPE-1:0]           tree_q;
  logic [(TOT-NUM_PES)*DATA_TYPE-1:0] tree_d;
  logic [L:0]                         vld_q;
  logic [1:0]                         op_q [0:L];
  logic [CNT_W-1:0]                   cnt_q;
  logic signed [DATA_TYPE-1:0]        acc_q;
  logic signed [DATA_TYPE-1:0]        root;
  logic signed [DATA_TYPE-1:0]        acc_d;
  logic                               out_valid_q;
  logic [DATA_TYPE-1:0]               data_out_q;
  logic                               en;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en || rst;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

  always_comb begin
    logic signed [DATA_TYPE-1:0] a, b, r;
    a = '0;
    b = '0;
    r = '0;
    tree_d = '0;
    for (int l = 1; l <= L; l++) begin
      for (int i = 0; i < NUM_PES; i++) begin
        if (i < lvl_cnt(l)) begin
          a = tree_q[(lvl_off(l-1) + 2*i)*DATA_TYPE +: DATA_TYPE];
          if (2*i + 1 < lvl_cnt(l-1)) begin
            b = tree_q[(lvl_off(l-1) + 2*i + 1)*DATA_TYPE +: DATA_TYPE];
            r = combine(op_q[l-1], a, b);
          end else begin
            r = a;
          end
          tree_d[(lvl_off(l) - NUM_PES + i)*DATA_TYPE +: DATA_TYPE] = r;
        end
      end
    end
  end

  // Stage boundary: input capture and tree levels
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[L-1:0], in_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (in_valid) begin
        tree_q[NUM_PES*DATA_TYPE-1:0] <= data_in;
        op_q[0]                       <= op;
      end
      for (int l = 1; l <= L; l++) begin
        if (vld_q[l-1]) begin
          for (int i = 0; i < NUM_PES; i++) begin
            if (i < lvl_cnt(l))
              tree_q[(lvl_off(l) + i)*DATA_TYPE +: DATA_TYPE] <=
                tree_d[(lvl_off(l) - NUM_PES + i)*DATA_TYPE +: DATA_TYPE];
          end
          op_q[l] <= op_q[l-1];
        end
      end
    end
  end

  always_comb begin
    root  = tree_q[(TOT-1)*DATA_TYPE +: DATA_TYPE];
    acc_d = (cnt_q == '0) ? root : combine(op_q[L], acc_q, root);
  end

  // Stage boundary: frame accumulator and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else if (en) begin
      out_valid_q <= 1'b0;
      if (vld_q[L]) begin
        if (cnt_q == LAST_BEAT) begin
          cnt_q       <= '0;
          out_valid_q <= 1'b1;
          data_out_q  <= acc_d;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= acc_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_reduce_tree_dist.sv
// Scoreboard bench for reduce_tree_dist: 5 lanes, 16-bit data, 3-beat frames.
`timescale 1ns/1ps
module tb_reduce_tree_dist;
  localparam int NP = 5;
  localparam int DW = 16;
  localparam int FL = 3;
  localparam int L  = $clog2(NP);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [NP*DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;

  reduce_tree_dist #(.NUM_PES(NP), .DATA_TYPE(DW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int acc_cyc; int stalls; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sx(input int v);
    logic signed [DW-1:0] t;
    t = v[DW-1:0];
    return int'(t);
  endfunction

  function automatic int fold_op(input int o, input int a, input int b);
    int s;
    case (o)
      0: begin
        s = a + b;
`ifdef REDUCE_TREE_DIST_SAT_EN
        if (s > 2**(DW-1) - 1) s = 2**(DW-1) - 1;
        else if (s < -(2**(DW-1))) s = -(2**(DW-1));
`endif
        return sx(s);
      end
      1: return (a > b) ? a : b;
      2: return ((a & 1) != 0) ? a : b;
      default: return (a < b) ? a : b;
    endcase
  endfunction

  function automatic int tree_fold(input int o, input int v[$]);
    int cur[$];
    int nxt[$];
    cur = v;
    while (cur.size() > 1) begin
      nxt = {};
      for (int k = 0; k < cur.size(); k += 2) begin
        if (k + 1 < cur.size()) nxt.push_back(fold_op(o, cur[k], cur[k+1]));
        else nxt.push_back(cur[k]);
      end
      cur = nxt;
    end
    return cur[0];
  endfunction

  // ---------------- acceptance side: push expectations ----------------
  int frame_pos = 0;
  int acc_m = 0;
  int lanes_m[$];
  int r_m;
  exp_t e_m;

  always @(negedge clk) begin
    if (rst) begin
      frame_pos = 0;
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      lanes_m.delete();
      for (int i = 0; i < NP; i++) lanes_m.push_back(sx(int'(data_in[i*DW +: DW])));
      r_m = tree_fold(int'(op), lanes_m);
      acc_m = (frame_pos == 0) ? r_m : fold_op(int'(op), acc_m, r_m);
      if (frame_pos == FL - 1) begin
        e_m.val = acc_m;
        e_m.acc_cyc = cyc + 1;
        e_m.stalls = stall_cnt;
        exp_q.push_back(e_m);
        frame_pos = 0;
      end else begin
        frame_pos = frame_pos + 1;
      end
    end
  end

  // ---------------- monitor: pop and compare ----------------
  logic rst_seen = 1'b0;
  logic fresh = 1'b1;
  int tmp_m;
  logic [DW-1:0] ev_m;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", in_ready, 1);
      if (rst_seen) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
      end
      rst_seen = 1'b1;
      fresh = 1'b1;
    end else begin
      rst_seen = 1'b0;
      chk("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got data_out=%0h, want no output (cycle %0d)", data_out, cyc);
        end else begin
          if (fresh)
            chk("latency", cyc - exp_q[0].acc_cyc, L + 1 + stall_cnt - exp_q[0].stalls);
          tmp_m = exp_q[0].val;
          ev_m = tmp_m[DW-1:0];
          chk("data_out", data_out, ev_m);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      fresh = !out_valid || out_ready;
      if (out_valid && !out_ready) stall_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int ln[NP]);
    for (int i = 0; i < NP; i++) data_in[i*DW +: DW] = DW'(ln[i]);
  endtask

  task automatic send(input logic [1:0] o, input int ln[NP]);
    op = o;
    set_lanes(ln);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  function automatic int rnd_lane();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(16'h7000, 16'h7FFF));
      1:       return -int'($urandom_range(16'h7000, 16'h8000));
      2:       return int'($urandom_range(0, 20)) - 10;
      default: return int'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  initial begin
    int w;
    int ln[NP];
    rst = 1'b1;
    in_valid = 1'b0;
    op = 2'd0;
    data_in = '0;
    out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // directed frames, back to back
    send(2'd0, '{1, 2, 3, 4, 0});
    send(2'd0, '{2, 4, 6, 8, 0});
    send(2'd0, '{3, 6, 9, 12, 0});
    for (int k = 0; k < FL; k++) send(2'd1, '{-3, 7, 2, -8, 5});
    for (int k = 0; k < FL; k++) send(2'd3, '{-3, 7, 2, -8, 5});
    for (int k = 0; k < FL; k++) send(2'd2, '{3, 4, 6, 9, 5});
    for (int k = 0; k < FL; k++) send(2'd0, '{16'h7000, 16'h7000, 0, 0, 0});
    for (int k = 0; k < FL; k++) send(2'd0, '{-32768, -32768, 1, 0, 0});
    repeat (8) step();

    // backpressure: frame result must hold while out_ready is low
    out_ready = 1'b0;
    send(2'd0, '{1, 2, 3, 4, 0});
    send(2'd0, '{2, 4, 6, 8, 0});
    send(2'd0, '{3, 6, 9, 12, 0});
    w = 0;
    while (!out_valid && w < 30) begin
      step();
      w++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL bp_wait: got no out_valid within 30 cycles, want a frame result");
    end
    in_valid = 1'b1;
    set_lanes('{9, 9, 9, 9, 9});
    for (int k = 0; k < 4; k++) begin
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();

    // randomized traffic with random backpressure and mid-stream resets
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 1500 || c == 1501 || c == 2300 || c == 2301);
      in_valid = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3));
      for (int i = 0; i < NP; i++) ln[i] = rnd_lane();
      set_lanes(ln);
      out_ready = ($urandom_range(0, 4) != 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
